fsm_pkt_framer: RTL and testbench
=================================

// Module: fsm_pkt_framer
// PURPOSE
//  Transmit side of the fsm_par_mux packet link. Frames payload bytes into BUS_SIZE
//  bus words: header in the upper word, payload in the middle, sequence number in
//  the lower word. A packet is WORD_NUM words with sequence 0..WORD_NUM-1.
//  Drives the receiver's bus_data_in. Can corrupt the header or sequence field on
//  request, so receiver error paths can be exercised.
// PARAMETERS
//  BUS_SIZE   16                  bus word width
//  WORD_SIZE  4                   header and sequence field width
//  WORD_NUM   BUS_SIZE/WORD_SIZE  words per packet (sequence wraps here)
//  HDR        {WORD_SIZE{1'b1}}   legal header value (4'hF)
//  ERR_HDR    4'h9                header emitted when inj_hdr_err is set
// PORTS
//  clk            in   1                     clock, all logic on posedge
//  reset          in   1                     synchronous, active-high
//  payload_in     in   BUS_SIZE-2*WORD_SIZE  payload (PW = 8 by default)
//  payload_valid  in   1                     payload_in is valid
//  payload_ready  out  1                     framer accepts payload this cycle
//  inj_hdr_err    in   1                     with accepted payload: use ERR_HDR as header
//  inj_seq_err    in   1                     with accepted payload: emit (seq+1)%WORD_NUM
//  bus_data_out   out  BUS_SIZE              framed word {hdr, payload, seq}
//  bus_valid      out  1                     bus_data_out holds a frame word
//  pkt_done       out  1                     1-cycle pulse with the seq=WORD_NUM-1 word
//  state          out  5                     one-hot FSM state
// BEHAVIOUR
//  - Reset is synchronous and active-high; one clock.
//  - While reset=1 at a posedge: state=RESET(5'b00001), bus_data_out=0, bus_valid=0,
//    pkt_done=0, payload_ready=0, seq counter=0. Reset has priority over all inputs,
//    including mid-packet: the partial packet is dropped with no pkt_done.
//  - States: RESET 00001, IDLE 00010, SEND 00100, STALL 01000, DONE 10000.
//  - RESET -> IDLE on the first posedge with reset=0.
//  - Accept = payload_valid & payload_ready.
//  - payload_ready=1 in IDLE, SEND, STALL and DONE; 0 in RESET.
//  - Accepted payload appears on bus_data_out with bus_valid=1 on the next posedge
//    (latency 1). Word = {hdr, payload_in, seq_field}, all registered.
//    * hdr = inj_hdr_err ? ERR_HDR : HDR
//    * seq_field = inj_seq_err ? (seq+1)%WORD_NUM : seq
//  - Internal seq always advances by 1 per accept, regardless of injection. It wraps
//    WORD_NUM-1 -> 0.
//  - Transitions on each posedge (reset=0):
//    * IDLE: accept -> SEND; else stay IDLE.
//    * SEND / STALL: accept of a word with seq<WORD_NUM-1 -> SEND; accept of the
//      seq=WORD_NUM-1 word -> DONE; no accept -> STALL.
//    * DONE: accept -> SEND (back-to-back packet, seq 0); else -> IDLE.
//  - In STALL and IDLE: bus_valid=0, bus_data_out=0. The receiver sees a hole;
//    packet resumes at the held seq.
//  - pkt_done=1 exactly in the cycle the seq=WORD_NUM-1 word is driven (state DONE).
//  - Injection inputs are ignored when no accept occurs.
//  - Widths: seq is clog2(WORD_NUM) bits, zero-extended to WORD_SIZE.
//    PW = BUS_SIZE-2*WORD_SIZE.
// TESTING
//  T1 basic packet: payloads FF,CB,F9,CD on 4 cycles -> bus FFF0,FCB1,FF92,FCD3,
//     bus_valid=1 for 4 cycles, pkt_done=1 with FCD3, then IDLE and bus=0.
//  T2 back-to-back: 8 consecutive payloads AB,88,77,74,57,71,7F,99 ->
//     FAB0,F881,F772,F743,F570,F711,F7F2,F993, no gaps, pkt_done twice.
//  T3 stall: payload_valid=0 for 2 cycles after FCB1 -> state STALL, bus_valid=0,
//     bus=0; resume with F9 -> FF92 (seq continues at 2).
//  T4 header error: inj_hdr_err=1 with 4th payload 99 -> 9993. Seq still wraps;
//     next packet starts at F..0.
//  T5 seq error: inj_seq_err=1 with 2nd payload 77 -> F772. Next payload F9 -> FF92
//     (internal seq unaffected).
//  T6 reset mid-packet: reset=1 after F881 -> next posedge state=00001, bus=0,
//     no pkt_done. After release, first payload FF -> FFF0.

Source files
------------

// File: rtl/fsm_pkt_framer.sv
`default_nettype none
// ============================================================================
// Module   : fsm_pkt_framer
// Brief    : Frames payload bytes into {hdr, payload, seq} bus words, WORD_NUM
//            words per packet, with optional header/sequence fault injection.
// Revision : 1.0  initial release
// ============================================================================
module fsm_pkt_framer #(
    parameter int                    BUS_SIZE  = 16,
    parameter int                    WORD_SIZE = 4,
    parameter int                    WORD_NUM  = BUS_SIZE / WORD_SIZE,
    parameter logic [WORD_SIZE-1:0]  HDR       = {WORD_SIZE{1'b1}},
    parameter logic [WORD_SIZE-1:0]  ERR_HDR   = WORD_SIZE'(4'h9)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [BUS_SIZE-2*WORD_SIZE-1:0] payload_in,
    input  logic                            payload_valid,
    output logic                            payload_ready,
    input  logic                            inj_hdr_err,
    input  logic                            inj_seq_err,
    output logic [BUS_SIZE-1:0]             bus_data_out,
    output logic                            bus_valid,
    output logic                            pkt_done,
    output logic [4:0]                      state
);

    localparam int c_seq_w = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;
    localparam logic [c_seq_w-1:0] c_seq_last = c_seq_w'(WORD_NUM - 1);

    typedef enum logic [4:0] {
        S_RESET = 5'b00001,
        S_IDLE  = 5'b00010,
        S_SEND  = 5'b00100,
        S_STALL = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_seq_w-1:0]   r_seq;
    logic [c_seq_w-1:0]   w_seq_inc;
    logic [c_seq_w-1:0]   w_seq_field;
    logic [WORD_SIZE-1:0] w_hdr;
    logic [BUS_SIZE-1:0]  w_word;
    logic [BUS_SIZE-1:0]  r_bus_data;
    logic                 w_accept;
    logic                 w_last;

    assign payload_ready = (r_state != S_RESET);
    assign w_accept      = payload_valid & payload_ready;
    assign w_last        = (r_seq == c_seq_last);
    assign w_seq_inc     = w_last ? '0 : r_seq + 1'b1;

    // Injection only alters the emitted field; r_seq always advances normally.
    assign w_seq_field   = inj_seq_err ? w_seq_inc : r_seq;
    assign w_hdr         = inj_hdr_err ? ERR_HDR : HDR;
    assign w_word        = {w_hdr, payload_in, WORD_SIZE'(w_seq_field)};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_RESET;
            r_seq      <= '0;
            r_bus_data <= '0;
        end else begin
            r_state    <= w_next;
            r_bus_data <= w_accept ? w_word : '0;
            if (w_accept) begin
                r_seq <= w_seq_inc;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET: w_next = S_IDLE;
            S_IDLE:  w_next = w_accept ? (w_last ? S_DONE : S_SEND) : S_IDLE;
            S_SEND,
            S_STALL: w_next = w_accept ? (w_last ? S_DONE : S_SEND) : S_STALL;
            S_DONE:  w_next = w_accept ? (w_last ? S_DONE : S_SEND) : S_IDLE;
            default: w_next = S_RESET;
        endcase
    end

    assign bus_data_out = r_bus_data;
    assign bus_valid    = (r_state == S_SEND) || (r_state == S_DONE);
    assign pkt_done     = (r_state == S_DONE);
    assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fsm_pkt_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_pkt_framer
// Brief    : Directed and random stimulus for fsm_pkt_framer against a
//            packet-position reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fsm_pkt_framer;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  payload_in;
    logic        payload_valid;
    logic        payload_ready;
    logic        inj_hdr_err;
    logic        inj_seq_err;
    logic [15:0] bus_data_out;
    logic        bus_valid;
    logic        pkt_done;
    logic [4:0]  state;

    always #5 clk = ~clk;

    fsm_pkt_framer dut (
        .clk           (clk),
        .reset         (reset),
        .payload_in    (payload_in),
        .payload_valid (payload_valid),
        .payload_ready (payload_ready),
        .inj_hdr_err   (inj_hdr_err),
        .inj_seq_err   (inj_seq_err),
        .bus_data_out  (bus_data_out),
        .bus_valid     (bus_valid),
        .pkt_done      (pkt_done),
        .state         (state)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: word position inside the current packet plus spec state.
    int          m_pos   = 0;
    logic        m_known = 1'b0;
    logic [4:0]  m_state = 5'b00001;
    logic [15:0] m_word  = '0;
    logic        m_valid = 1'b0;
    logic        m_done  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: apply inputs, advance one posedge, check at next negedge.
    task automatic cycle(input logic r, input logic v, input logic [7:0] p,
                         input logic h, input logic s);
        logic acc;
        reset = r; payload_valid = v; payload_in = p; inj_hdr_err = h; inj_seq_err = s;
        #1;
        if (m_known) check("ready", 32'(payload_ready), 32'(m_state != 5'b00001));
        acc = v && m_known && (m_state != 5'b00001);
        if (r) begin
            m_state = 5'b00001; m_pos = 0; m_word = '0; m_valid = 0; m_done = 0; m_known = 1;
        end else if (acc) begin
            m_word  = {(h ? 4'h9 : 4'hF), p, 4'(s ? (m_pos + 1) % N : m_pos)};
            m_valid = 1'b1;
            m_done  = (m_pos == N - 1);
            m_state = m_done ? 5'b10000 : 5'b00100;
            m_pos   = (m_pos + 1) % N;
        end else begin
            m_word  = '0; m_valid = 0; m_done = 0;
            m_state = (m_state == 5'b00100 || m_state == 5'b01000) ? 5'b01000 : 5'b00010;
        end
        @(posedge clk);
        @(negedge clk);
        check("state", 32'(state), 32'(m_state));
        check("bus_data", 32'(bus_data_out), 32'(m_word));
        check("bus_valid", 32'(bus_valid), 32'(m_valid));
        check("pkt_done", 32'(pkt_done), 32'(m_done));
    endtask

    task automatic send(input logic [7:0] p, input logic [15:0] lit, input string tag);
        cycle(0, 1, p, 0, 0);
        check(tag, 32'(bus_data_out), 32'(lit));
    endtask

    logic [7:0]  t2p [8] = '{8'hAB, 8'h88, 8'h77, 8'h74, 8'h57, 8'h71, 8'h7F, 8'h99};
    logic [15:0] t2e [8] = '{16'hFAB0, 16'hF881, 16'hF772, 16'hF743,
                             16'hF570, 16'hF711, 16'hF7F2, 16'hF993};

    initial begin
        reset = 1; payload_valid = 0; payload_in = '0; inj_hdr_err = 0; inj_seq_err = 0;
        @(negedge clk);
        cycle(1, 1, 8'h55, 0, 0);
        check("rst_state", 32'(state), 32'h01);
        check("rst_bus", 32'(bus_data_out), 32'h0);
        cycle(1, 0, 8'h00, 0, 0);
        cycle(0, 0, 8'h00, 0, 0);
        check("idle_state", 32'(state), 32'h02);

        // T1 basic packet
        send(8'hFF, 16'hFFF0, "t1_w0");
        send(8'hCB, 16'hFCB1, "t1_w1");
        send(8'hF9, 16'hFF92, "t1_w2");
        send(8'hCD, 16'hFCD3, "t1_w3");
        check("t1_done", 32'(pkt_done), 32'h1);
        cycle(0, 0, 8'h00, 0, 0);
        check("t1_idle", 32'(state), 32'h02);

        // T2 back-to-back
        for (int i = 0; i < 8; i++) send(t2p[i], t2e[i], "t2_word");
        cycle(0, 0, 8'h00, 0, 0);

        // T3 stall
        send(8'hFF, 16'hFFF0, "t3_w0");
        send(8'hCB, 16'hFCB1, "t3_w1");
        cycle(0, 0, 8'h00, 0, 0);
        cycle(0, 0, 8'h00, 0, 0);
        check("t3_stall", 32'(state), 32'h08);
        send(8'hF9, 16'hFF92, "t3_w2");
        send(8'hCD, 16'hFCD3, "t3_w3");

        // T4 header error on the last word, then T5 sequence error
        send(8'hAB, 16'hFAB0, "t4_w0");
        send(8'h88, 16'hF881, "t4_w1");
        send(8'h77, 16'hF772, "t4_w2");
        cycle(0, 1, 8'h99, 1, 0);
        check("t4_hdr", 32'(bus_data_out), 32'h9993);
        check("t4_done", 32'(pkt_done), 32'h1);
        send(8'hFF, 16'hFFF0, "t4_next");
        cycle(0, 1, 8'h77, 0, 1);
        check("t5_seq", 32'(bus_data_out), 32'hF772);
        send(8'hF9, 16'hFF92, "t5_after");
        send(8'hCD, 16'hFCD3, "t5_last");

        // T6 reset mid-packet
        send(8'hAB, 16'hFAB0, "t6_w0");
        send(8'h88, 16'hF881, "t6_w1");
        cycle(1, 1, 8'h77, 0, 0);
        check("t6_state", 32'(state), 32'h01);
        check("t6_nodone", 32'(pkt_done), 32'h0);
        cycle(0, 1, 8'h77, 0, 0);
        send(8'hFF, 16'hFFF0, "t6_restart");

        // Random phase
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                  8'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
